// File: rtl/note_pkg.sv
// Shared types and constants for the chart-driven note dispatcher.
// Chart entry and spawn record layouts, FSM states and the due-time helper.
package note_pkg;

  localparam int CHART_DEPTH = 512;
  localparam int ADDR_W      = 9;
  localparam int LEAD        = 120;
  localparam int FIFO_DEPTH  = 8;
  localparam int LANE_W      = 2;
  localparam int TIME_W      = 16;
  localparam int END_BIT     = 19;
  localparam int HOLD_BIT    = 18;
  localparam int ENTRY_W     = 20;

  typedef struct packed {
    logic              end_mark;
    logic              hold;
    logic [LANE_W-1:0] lane;
    logic [TIME_W-1:0] hit_time;
  } chart_entry_t;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [TIME_W-1:0] hit_time;
    logic              hold;
  } spawn_rec_t;

  localparam int SPAWN_W = $bits(spawn_rec_t);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Widened to 17 bits so now + lead never wraps past the 16-bit song clock.
  function automatic logic is_due(input logic [TIME_W-1:0] now,
                                  input logic [TIME_W-1:0] hit,
                                  input logic [TIME_W:0]   lead);
    return ({1'b0, now} + lead) >= {1'b0, hit};
  endfunction

endpackage

// File: rtl/spawn_fifo.sv
// First-word fall-through FIFO for spawn records, with synchronous flush.
// The head reads as zero while empty so downstream never sees stale data.
module spawn_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; flush discards everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, cleared on reset so no X ever reaches the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/note_dispatcher.sv
// Walks the note chart ROM and spawns each note LEAD frames before its hit time.
// Spawns queue in a FIFO and leave through a valid/ready handshake.
module note_dispatcher
  import note_pkg::*;
#(
  parameter int CHART_DEPTH = note_pkg::CHART_DEPTH,
  parameter int ADDR_W      = note_pkg::ADDR_W,
  parameter int LEAD        = note_pkg::LEAD,
  parameter int FIFO_DEPTH  = note_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_sign,
  input  logic              stop_sign,
  input  logic [15:0]       un_time,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [19:0]       rom_data,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [1:0]        spawn_lane,
  output logic [15:0]       spawn_hit_time,
  output logic              spawn_hold,
  output logic              chart_done,
  output logic [7:0]        late_cnt
);

  state_t       state_r;
  state_t       next_state_s;
  chart_entry_t entry_s;
  spawn_rec_t   push_rec_s;
  spawn_rec_t   head_s;
  logic         push_s;
  logic         flush_s;
  logic         late_inc_s;
  logic         addr_clr_s;
  logic         addr_inc_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic         pop_s;
  logic         late_s;
  logic         due_s;
  logic         last_addr_s;

  assign entry_s     = chart_entry_t'(rom_data);
  assign late_s      = entry_s.hit_time < un_time;
  assign due_s       = is_due(un_time, entry_s.hit_time, 17'(LEAD));
  assign last_addr_s = (rom_addr == ADDR_W'(CHART_DEPTH - 1));
  assign push_rec_s  = '{lane: entry_s.lane, hit_time: entry_s.hit_time, hold: entry_s.hold};

  // Next-state and control decode; stop overrides every other decision.
  always_comb begin
    next_state_s = state_r;
    push_s       = 1'b0;
    flush_s      = 1'b0;
    late_inc_s   = 1'b0;
    addr_clr_s   = 1'b0;
    addr_inc_s   = 1'b0;
    if (stop_sign && (state_r != S_IDLE)) begin
      next_state_s = S_DONE;
      flush_s      = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_sign && stop_sign) begin
            next_state_s = S_DONE;
            flush_s      = 1'b1;
          end else if (start_sign) begin
            next_state_s = S_FETCH;
            addr_clr_s   = 1'b1;
            flush_s      = 1'b1;
          end else begin
            next_state_s = S_IDLE;
          end
        end
        S_FETCH: next_state_s = S_WAIT;
        S_WAIT:  next_state_s = S_COMPARE;
        S_COMPARE: begin
          if (entry_s.end_mark) begin
            next_state_s = S_DONE;
          end else if (late_s || (due_s && !fifo_full_s)) begin
            late_inc_s = late_s;
            push_s     = ~late_s;
            if (last_addr_s) begin
              next_state_s = S_DONE;
            end else begin
              addr_inc_s   = 1'b1;
              next_state_s = S_FETCH;
            end
          end else begin
            next_state_s = S_COMPARE;
          end
        end
        S_DONE: begin
          if (start_sign) begin
            next_state_s = S_FETCH;
            addr_clr_s   = 1'b1;
            flush_s      = 1'b1;
          end else begin
            next_state_s = S_DONE;
          end
        end
        default: next_state_s = S_IDLE;
      endcase
    end
  end

  // State, chart address, done flag and saturating late counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      rom_addr   <= {ADDR_W{1'b0}};
      chart_done <= 1'b0;
      late_cnt   <= 8'd0;
    end else begin
      state_r    <= next_state_s;
      chart_done <= (next_state_s == S_DONE);
      if (addr_clr_s) begin
        rom_addr <= {ADDR_W{1'b0}};
      end else if (addr_inc_s) begin
        rom_addr <= rom_addr + 1'b1;
      end
      if (addr_clr_s) begin
        late_cnt <= 8'd0;
      end else if (late_inc_s && (late_cnt != 8'hFF)) begin
        late_cnt <= late_cnt + 8'd1;
      end
    end
  end

  assign pop_s = spawn_valid & spawn_ready;

  spawn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SPAWN_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush_s),
    .push  (push_s),
    .din   (push_rec_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign spawn_valid    = ~fifo_empty_s;
  assign spawn_lane     = head_s.lane;
  assign spawn_hit_time = head_s.hit_time;
  assign spawn_hold     = head_s.hold;

endmodule

// File: tb/tb_note_dispatcher.sv
// Scoreboard bench for note_dispatcher: a behavioural 1-cycle ROM feeds the DUT,
// expected spawns are queued as stimulus is driven and checked on each handshake.
module tb_note_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_sign;
  logic        stop_sign;
  logic [15:0] un_time;
  logic [8:0]  rom_addr;
  logic [19:0] rom_data;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [1:0]  spawn_lane;
  logic [15:0] spawn_hit_time;
  logic        spawn_hold;
  logic        chart_done;
  logic [7:0]  late_cnt;

  logic [19:0] rom [512];
  logic [18:0] sb [$];
  int checks = 0;
  int failures = 0;

  note_dispatcher dut (
    .clk            (clk),
    .reset          (reset),
    .start_sign     (start_sign),
    .stop_sign      (stop_sign),
    .un_time        (un_time),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .spawn_valid    (spawn_valid),
    .spawn_ready    (spawn_ready),
    .spawn_lane     (spawn_lane),
    .spawn_hit_time (spawn_hit_time),
    .spawn_hold     (spawn_hold),
    .chart_done     (chart_done),
    .late_cnt       (late_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Handshake happens at the next rising edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (!reset && spawn_valid && spawn_ready) begin
      logic [18:0] exp_rec;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spawn_unexpected got lane=%0d hit=%0d hold=%0d, none expected",
                 spawn_lane, spawn_hit_time, spawn_hold);
      end else begin
        exp_rec = sb.pop_front();
        if ({spawn_lane, spawn_hit_time, spawn_hold} !== exp_rec) begin
          failures++;
          $display("FAIL spawn_order got lane=%0d hit=%0d hold=%0d expected lane=%0d hit=%0d hold=%0d",
                   spawn_lane, spawn_hit_time, spawn_hold, exp_rec[18:17], exp_rec[16:1], exp_rec[0]);
        end
      end
    end
  end

  function automatic logic [19:0] mk(input logic [15:0] hit, input logic [1:0] lane,
                                     input logic hold, input logic endm);
    return {endm, hold, lane, hit};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_sign = 1'b1;
    step();
    start_sign = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = mk(16'd0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if ({rom_addr, spawn_valid, spawn_lane, spawn_hit_time, spawn_hold, chart_done, late_cnt} !== 38'd0) begin
      failures++;
      $display("FAIL reset_values got addr=%0d valid=%0b lane=%0d hit=%0d hold=%0b done=%0b late=%0d, all zero required",
               rom_addr, spawn_valid, spawn_lane, spawn_hit_time, spawn_hold, chart_done, late_cnt);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    clear_rom();
    rom[0] = mk(16'd200, 2'd1, 1'b0, 1'b0);
    rom[1] = mk(16'd200, 2'd2, 1'b1, 1'b0);
    spawn_ready = 1'b1;
    un_time = 16'd0;
    pulse_start();
    for (int t = 0; t <= 85; t++) begin
      un_time = 16'(t);
      if (t == 80) begin
        sb.push_back({2'd1, 16'd200, 1'b0});
        sb.push_back({2'd2, 16'd200, 1'b1});
      end
      repeat (4) step();
      if (t == 79) begin
        checks++;
        if (chart_done !== 1'b0) begin
          failures++;
          $display("FAIL basic_not_done_early got %0b required 0", chart_done);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL basic_spawn_count got %0d left required 0", sb.size());
    end
    checks++;
    if (chart_done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done got %0b required 1", chart_done);
    end
  endtask

  task automatic test_late();
    clear_rom();
    rom[0] = mk(16'd5, 2'd0, 1'b0, 1'b0);
    rom[1] = mk(16'd300, 2'd3, 1'b1, 1'b0);
    spawn_ready = 1'b1;
    un_time = 16'd10;
    pulse_start();
    repeat (10) step();
    checks++;
    if ({late_cnt, rom_addr, spawn_valid} !== {8'd1, 9'd1, 1'b0}) begin
      failures++;
      $display("FAIL late_drop got late=%0d addr=%0d valid=%0b required late=1 addr=1 valid=0",
               late_cnt, rom_addr, spawn_valid);
    end
    un_time = 16'd179;
    repeat (6) step();
    checks++;
    if (spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL late_not_due_179 got valid=%0b required 0", spawn_valid);
    end
    sb.push_back({2'd3, 16'd300, 1'b1});
    un_time = 16'd180;
    repeat (10) step();
    checks++;
    if (sb.size() != 0 || chart_done !== 1'b1 || late_cnt !== 8'd1) begin
      failures++;
      $display("FAIL late_due_180 got left=%0d done=%0b late=%0d required left=0 done=1 late=1",
               sb.size(), chart_done, late_cnt);
    end
  endtask

  task automatic load_ten();
    clear_rom();
    for (int i = 0; i < 10; i++) rom[i] = mk(16'd100, 2'(i), 1'(i), 1'b0);
  endtask

  task automatic test_full();
    load_ten();
    spawn_ready = 1'b0;
    un_time = 16'd50;
    for (int i = 0; i < 10; i++) sb.push_back({2'(i), 16'd100, 1'(i)});
    pulse_start();
    checks++;
    if (rom_addr !== 9'd0) begin
      failures++;
      $display("FAIL latency_addr got %0d required 0", rom_addr);
    end
    step();
    step();
    checks++;
    if (spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_k2 got valid=%0b required 0", spawn_valid);
    end
    step();
    checks++;
    if (spawn_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_k3 got valid=%0b required 1", spawn_valid);
    end
    repeat (60) step();
    checks++;
    if ({rom_addr, chart_done, spawn_valid, spawn_lane, spawn_hit_time, spawn_hold}
        !== {9'd8, 1'b0, 1'b1, 2'd0, 16'd100, 1'b0}) begin
      failures++;
      $display("FAIL full_stall got addr=%0d done=%0b valid=%0b lane=%0d hit=%0d hold=%0b required addr=8 done=0 valid=1 lane=0 hit=100 hold=0",
               rom_addr, chart_done, spawn_valid, spawn_lane, spawn_hit_time, spawn_hold);
    end
    spawn_ready = 1'b1;
    repeat (60) step();
    checks++;
    if (sb.size() != 0 || chart_done !== 1'b1 || spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_drain got left=%0d done=%0b valid=%0b required left=0 done=1 valid=0",
               sb.size(), chart_done, spawn_valid);
    end
  endtask

  task automatic test_stop();
    load_ten();
    spawn_ready = 1'b0;
    un_time = 16'd50;
    pulse_start();
    repeat (9) step();
    checks++;
    if (spawn_valid !== 1'b1 || rom_addr !== 9'd3) begin
      failures++;
      $display("FAIL stop_pre got valid=%0b addr=%0d required valid=1 addr=3", spawn_valid, rom_addr);
    end
    stop_sign = 1'b1;
    step();
    stop_sign = 1'b0;
    checks++;
    if ({spawn_valid, chart_done, rom_addr} !== {1'b0, 1'b1, 9'd3}) begin
      failures++;
      $display("FAIL stop_flush got valid=%0b done=%0b addr=%0d required valid=0 done=1 addr=3",
               spawn_valid, chart_done, rom_addr);
    end
    repeat (8) step();
    checks++;
    if (rom_addr !== 9'd3 || spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL stop_hold got addr=%0d valid=%0b required addr=3 valid=0", rom_addr, spawn_valid);
    end
  endtask

  task automatic test_async_reset();
    load_ten();
    spawn_ready = 1'b0;
    un_time = 16'd50;
    pulse_start();
    repeat (5) step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({rom_addr, spawn_valid, spawn_lane, spawn_hit_time, spawn_hold, chart_done, late_cnt} !== 38'd0) begin
      failures++;
      $display("FAIL async_reset got addr=%0d valid=%0b lane=%0d hit=%0d hold=%0b done=%0b late=%0d required all zero",
               rom_addr, spawn_valid, spawn_lane, spawn_hit_time, spawn_hold, chart_done, late_cnt);
    end
    step();
    reset = 1'b0;
    step();
    spawn_ready = 1'b1;
    for (int i = 0; i < 10; i++) sb.push_back({2'(i), 16'd100, 1'(i)});
    pulse_start();
    checks++;
    if (rom_addr !== 9'd0) begin
      failures++;
      $display("FAIL restart_addr got %0d required 0", rom_addr);
    end
    repeat (50) step();
    checks++;
    if (sb.size() != 0 || chart_done !== 1'b1) begin
      failures++;
      $display("FAIL restart_run got left=%0d done=%0b required left=0 done=1", sb.size(), chart_done);
    end
  endtask

  task automatic test_saturate();
    int n;
    for (int i = 0; i < 512; i++) rom[i] = mk(16'd0, 2'd1, 1'b0, 1'b0);
    spawn_ready = 1'b1;
    un_time = 16'd10;
    pulse_start();
    n = 0;
    while (chart_done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (chart_done !== 1'b1) begin
      failures++;
      $display("FAIL sat_timeout done=%0b after %0d cycles required 1", chart_done, n);
    end
    checks++;
    if (late_cnt !== 8'd255 || rom_addr !== 9'd511) begin
      failures++;
      $display("FAIL sat_count got late=%0d addr=%0d required late=255 addr=511", late_cnt, rom_addr);
    end
    repeat (10) step();
    checks++;
    if (rom_addr !== 9'd511 || spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_no_wrap got addr=%0d valid=%0b required addr=511 valid=0", rom_addr, spawn_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_sign = 1'b0;
    stop_sign = 1'b0;
    un_time = 16'd0;
    spawn_ready = 1'b0;
    clear_rom();
    test_reset();
    test_basic();
    test_late();
    test_full();
    test_stop();
    sb.delete();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
